// File: rtl/gpr_pkg.sv
// Shared types and helpers for the multi-port GPR bank.
// Index width derivation, hi-word bit, clear FSM states.
package gpr_pkg;

    typedef enum logic {
        GPR_CLEAR = 1'b0,
        GPR_READY = 1'b1
    } gpr_state_t;

    localparam int GPR_DATA_W = 32;
    localparam int GPR_NREGS  = 128;
    localparam int GPR_HIBIT  = GPR_NREGS / 2;

    typedef logic [GPR_DATA_W-1:0] gpr_word_t;

    function automatic int gprIdw(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    function automatic int gprHiBit(input int nregs);
        return nregs / 2;
    endfunction

endpackage

// File: rtl/gpr_read_port.sv
// One registered GPR read port: forms lo/hi indices, optional
// same-cycle write bypass (macro GPR_BYPASS_EN), output register.
// Ports: clk/reset, live (bank ready), en/qw/id request,
// loIdx/hiIdx to storage, loData/hiData from storage,
// flattened write-port bundle (pre-gated), vld/lo/hi outputs.
module gpr_read_port
    import gpr_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 128,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b0,
    parameter int IDW     = gprIdw(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  live,
    input  logic                  en,
    input  logic                  qw,
    input  logic [IDW-1:0]        id,
    output logic [IDW-1:0]        loIdx,
    output logic [IDW-1:0]        hiIdx,
    input  logic [DATA_W-1:0]     loData,
    input  logic [DATA_W-1:0]     hiData,
    input  logic [NWR-1:0]        wrEn,
    input  logic [NWR-1:0]        wrQw,
    input  logic [NWR*IDW-1:0]    wrId,
    input  logic [NWR*DATA_W-1:0] wrLo,
    input  logic [NWR*DATA_W-1:0] wrHi,
    output logic                  vld,
    output logic [DATA_W-1:0]     lo,
    output logic [DATA_W-1:0]     hi
);

    localparam logic [IDW-1:0] HIMASK = IDW'(gprHiBit(NREGS));

    logic [DATA_W-1:0] loWord;
    logic [DATA_W-1:0] hiWord;

    assign loIdx = id;
    assign hiIdx = id | HIMASK;

`ifdef GPR_BYPASS_EN
    logic [IDW-1:0] bypLo;
    logic [IDW-1:0] bypHi;

    // Walk ports in ascending order so the highest port wins,
    // and within a port the hi word lands after the lo word.
    always_comb begin
        loWord = loData;
        hiWord = hiData;
        bypLo  = '0;
        bypHi  = '0;
        for (int p = 0; p < NWR; p++) begin
            bypLo = wrId[p*IDW +: IDW];
            bypHi = bypLo | HIMASK;
            if (wrEn[p]) begin
                if (!ZERO_R0 || bypLo != '0) begin
                    if (bypLo == loIdx)
                        loWord = wrLo[p*DATA_W +: DATA_W];
                    if (bypLo == hiIdx)
                        hiWord = wrLo[p*DATA_W +: DATA_W];
                end
                if (wrQw[p]) begin
                    if (bypHi == loIdx)
                        loWord = wrHi[p*DATA_W +: DATA_W];
                    if (bypHi == hiIdx)
                        hiWord = wrHi[p*DATA_W +: DATA_W];
                end
            end
        end
    end
`else
    logic unusedWr;
    assign unusedWr = ^{wrEn, wrQw, wrId, wrLo, wrHi};
    assign loWord   = loData;
    assign hiWord   = hiData;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            vld <= 1'b0;
            lo  <= '0;
            hi  <= '0;
        end else if (en && live) begin
            vld <= 1'b1;
            lo  <= (ZERO_R0 && id == '0) ? '0 : loWord;
            hi  <= qw ? hiWord : '0;
        end else begin
            vld <= 1'b0;
        end
    end

endmodule

// File: rtl/gpr_bank_mp.sv
// Multi-port GPR bank: NRD registered read ports, NWR write
// ports with lo/hi quadword pairing, clear sequencer after reset.
// Ports: clk, reset (sync, active-high), ready, rd_* read bundle,
// wr_* write bundle. Macro GPR_BYPASS_EN enables write->read bypass.
module gpr_bank_mp
    import gpr_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 128,
    parameter int NRD     = 3,
    parameter int NWR     = 2,
    parameter bit ZERO_R0 = 1'b0,
    localparam int IDW    = gprIdw(NREGS)
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ready,
    input  logic [NRD-1:0]        rd_en,
    input  logic [NRD-1:0]        rd_qw,
    input  logic [NRD*IDW-1:0]    rd_id,
    output logic [NRD-1:0]        rd_vld,
    output logic [NRD*DATA_W-1:0] rd_lo,
    output logic [NRD*DATA_W-1:0] rd_hi,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR-1:0]        wr_qw,
    input  logic [NWR*IDW-1:0]    wr_id,
    input  logic [NWR*DATA_W-1:0] wr_lo,
    input  logic [NWR*DATA_W-1:0] wr_hi
);

    localparam logic [IDW-1:0] HIMASK = IDW'(gprHiBit(NREGS));
    localparam logic [IDW-1:0] LASTID = IDW'(NREGS - 1);

    gpr_state_t state, stateNext;
    logic [IDW-1:0] clrCnt, clrCntNext;
    logic [DATA_W-1:0] regs [NREGS];
    logic live;
    logic [NWR-1:0] wrLive;

    assign ready  = (state == GPR_READY);
    assign live   = ready && !reset;
    assign wrLive = wr_en & {NWR{live}};

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= GPR_CLEAR;
            clrCnt <= '0;
        end else begin
            state  <= stateNext;
            clrCnt <= clrCntNext;
        end
    end

    always_comb begin
        stateNext  = state;
        clrCntNext = clrCnt;
        if (state == GPR_CLEAR) begin
            clrCntNext = clrCnt + 1'b1;
            if (clrCnt == LASTID)
                stateNext = GPR_READY;
        end
    end

    // Later assignments override earlier ones: highest port wins,
    // and a port's hi word wins over its own lo on an aliased index.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (!ready) begin
                regs[clrCnt] <= '0;
            end else begin
                for (int p = 0; p < NWR; p++) begin
                    if (wrLive[p]) begin
                        if (!ZERO_R0 || wr_id[p*IDW +: IDW] != '0)
                            regs[wr_id[p*IDW +: IDW]] <=
                                wr_lo[p*DATA_W +: DATA_W];
                        if (wr_qw[p])
                            regs[wr_id[p*IDW +: IDW] | HIMASK] <=
                                wr_hi[p*DATA_W +: DATA_W];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NRD; g++) begin : gRd
        logic [IDW-1:0] loIdx, hiIdx;
        logic [DATA_W-1:0] loData, hiData;

        assign loData = regs[loIdx];
        assign hiData = regs[hiIdx];

        gpr_read_port #(
            .DATA_W  (DATA_W),
            .NREGS   (NREGS),
            .NWR     (NWR),
            .ZERO_R0 (ZERO_R0),
            .IDW     (IDW)
        ) uPort (
            .clk    (clk),
            .reset  (reset),
            .live   (live),
            .en     (rd_en[g]),
            .qw     (rd_qw[g]),
            .id     (rd_id[g*IDW +: IDW]),
            .loIdx  (loIdx),
            .hiIdx  (hiIdx),
            .loData (loData),
            .hiData (hiData),
            .wrEn   (wrLive),
            .wrQw   (wr_qw),
            .wrId   (wr_id),
            .wrLo   (wr_lo),
            .wrHi   (wr_hi),
            .vld    (rd_vld[g]),
            .lo     (rd_lo[g*DATA_W +: DATA_W]),
            .hi     (rd_hi[g*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_gpr_bank_mp.sv
// Self-checking bench for gpr_bank_mp (ZERO_R0=1, default sizes).
// Array-level reference model plus directed literal checks.
module tb_gpr_bank_mp;

    localparam int DW  = 32;
    localparam int NR  = 128;
    localparam int NRD = 3;
    localparam int NWR = 2;
    localparam int IDW = 7;
    localparam int H   = 64;
`ifdef GPR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic ready;
    logic [NRD-1:0] rd_en, rd_qw, rd_vld;
    logic [NRD*IDW-1:0] rd_id;
    logic [NRD*DW-1:0] rd_lo, rd_hi;
    logic [NWR-1:0] wr_en, wr_qw;
    logic [NWR*IDW-1:0] wr_id;
    logic [NWR*DW-1:0] wr_lo, wr_hi;

    always #5 clk = ~clk;

    gpr_bank_mp #(
        .DATA_W(DW), .NREGS(NR), .NRD(NRD),
        .NWR(NWR), .ZERO_R0(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .ready(ready),
        .rd_en(rd_en), .rd_qw(rd_qw), .rd_id(rd_id),
        .rd_vld(rd_vld), .rd_lo(rd_lo), .rd_hi(rd_hi),
        .wr_en(wr_en), .wr_qw(wr_qw), .wr_id(wr_id),
        .wr_lo(wr_lo), .wr_hi(wr_hi)
    );

    logic [DW-1:0] m [NR];
    int clrCnt;
    bit mReady;
    logic [NRD-1:0] eVld;
    logic [DW-1:0] eLo [NRD];
    logic [DW-1:0] eHi [NRD];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name,
                       input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] rdLo(
        input logic [DW-1:0] a [NR], input int id);
        return (id == 0) ? '0 : a[id];
    endfunction

    task automatic idle();
        rd_en = '0; rd_qw = '0; rd_id = '0;
        wr_en = '0; wr_qw = '0; wr_id = '0;
        wr_lo = '0; wr_hi = '0;
    endtask

    task automatic setWr(input int p, input bit qw, input int id,
                         input logic [DW-1:0] lo,
                         input logic [DW-1:0] hi);
        wr_en[p] = 1'b1;
        wr_qw[p] = qw;
        wr_id[p*IDW +: IDW] = IDW'(id);
        wr_lo[p*DW +: DW] = lo;
        wr_hi[p*DW +: DW] = hi;
    endtask

    task automatic setRd(input int p, input bit qw, input int id);
        rd_en[p] = 1'b1;
        rd_qw[p] = qw;
        rd_id[p*IDW +: IDW] = IDW'(id);
    endtask

    // Advance one clock: update model from current inputs,
    // then compare every DUT output after the edge.
    task automatic step();
        logic [DW-1:0] pre [NR];
        int id;
        pre = m;
        if (mReady && !reset) begin
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p]) begin
                    id = int'(wr_id[p*IDW +: IDW]);
                    if (id != 0) m[id] = wr_lo[p*DW +: DW];
                    if (wr_qw[p]) m[id | H] = wr_hi[p*DW +: DW];
                end
            end
        end
        for (int r = 0; r < NRD; r++) begin
            id = int'(rd_id[r*IDW +: IDW]);
            if (reset) begin
                eVld[r] = 1'b0; eLo[r] = '0; eHi[r] = '0;
            end else if (mReady && rd_en[r]) begin
                eVld[r] = 1'b1;
                eLo[r] = BYP ? rdLo(m, id) : rdLo(pre, id);
                eHi[r] = !rd_qw[r] ? '0 :
                         BYP ? m[id | H] : pre[id | H];
            end else begin
                eVld[r] = 1'b0;
            end
        end
        if (reset) begin
            mReady = 1'b0;
            clrCnt = 0;
        end else if (!mReady) begin
            clrCnt++;
            if (clrCnt == NR) begin
                mReady = 1'b1;
                foreach (m[i]) m[i] = '0;
            end
        end
        @(posedge clk);
        #1;
        chk("ready", 32'(ready), 32'(mReady));
        for (int r = 0; r < NRD; r++) begin
            chk($sformatf("vld%0d", r), 32'(rd_vld[r]), 32'(eVld[r]));
            chk($sformatf("lo%0d", r), rd_lo[r*DW +: DW], eLo[r]);
            chk($sformatf("hi%0d", r), rd_hi[r*DW +: DW], eHi[r]);
        end
    endtask

    task automatic waitReady(input string name);
        int n;
        n = 0;
        while (n < 300) begin
            step();
            n++;
            if (ready) break;
        end
        chk(name, 32'(n), 32'(NR));
    endtask

    function automatic int pickId();
        int lst [6];
        lst = '{0, 3, 7, 'h40, 'h43, 'h47};
        if ($urandom_range(1, 0) == 0)
            return lst[$urandom_range(5, 0)];
        return int'($urandom_range(NR - 1, 0));
    endfunction

    initial begin
        idle();
        foreach (m[i]) m[i] = '0;
        mReady = 1'b0;
        clrCnt = 0;
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        waitReady("clear_len");

        setRd(0, 0, 5);
        setRd(1, 1, 'h45);
        step();
        idle();
        chk("t1_rd5", rd_lo[0 +: DW], 32'h0);
        chk("t1_rd45", rd_lo[DW +: DW], 32'h0);

        setWr(0, 1, 3, 32'hDEADBEEF, 32'h12345678);
        step();
        idle();
        setRd(0, 1, 3);
        step();
        idle();
        chk("t2_vld", 32'(rd_vld[0]), 32'h1);
        chk("t2_lo", rd_lo[0 +: DW], 32'hDEADBEEF);
        chk("t2_hi", rd_hi[0 +: DW], 32'h12345678);

        setWr(0, 0, 7, 32'h11, 32'h0);
        setWr(1, 0, 7, 32'h22, 32'h0);
        step();
        idle();
        setRd(2, 0, 7);
        step();
        idle();
        chk("t3_prio", rd_lo[2*DW +: DW], 32'h22);

        setWr(0, 0, 7, 32'h33, 32'h0);
        setRd(0, 0, 7);
        step();
        idle();
        chk("t4_byp", rd_lo[0 +: DW], BYP ? 32'h33 : 32'h22);
        step();

        setWr(0, 0, 0, 32'hFFFF, 32'h0);
        step();
        idle();
        setRd(0, 0, 0);
        step();
        idle();
        chk("t5_r0", rd_lo[0 +: DW], 32'h0);
        setWr(1, 1, 0, 32'h1234, 32'hAB);
        step();
        idle();
        setRd(1, 0, 'h40);
        step();
        idle();
        chk("t5_hi0", rd_lo[DW +: DW], 32'hAB);

        setWr(0, 1, 3, 32'hA0, 32'hB0);
        setWr(1, 0, 'h43, 32'hC0, 32'h0);
        step();
        idle();
        setRd(0, 1, 3);
        step();
        idle();
        chk("qw_coll", rd_hi[0 +: DW], 32'hC0);

        for (int c = 0; c < 2000; c++) begin
            idle();
            for (int p = 0; p < NWR; p++)
                if ($urandom_range(2, 0) != 0)
                    setWr(p, 1'($urandom), pickId(),
                          $urandom, $urandom);
            for (int r = 0; r < NRD; r++)
                if ($urandom_range(2, 0) != 0)
                    setRd(r, 1'($urandom), pickId());
            step();
        end
        idle();

        setWr(0, 0, 9, 32'h5, 32'h0);
        step();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (40) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        waitReady("reclear_len");
        setRd(0, 0, 9);
        step();
        idle();
        chk("t6_rd9", rd_lo[0 +: DW], 32'h0);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
